// File: rtl/ps2_counter_bcd.sv
// Sequential binary-to-BCD converter for the PS/2 mouse z-count and button counts.
// One double-dabble step per cycle on all four values; digits update only on done_tick.
module ps2_counter_bcd (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] z_count,
    input  logic [7:0]  left_count,
    input  logic [7:0]  middle_count,
    input  logic [7:0]  right_count,
    output logic [3:0]  z_axis_ten_thousands,
    output logic [3:0]  z_axis_thousands,
    output logic [3:0]  z_axis_hundreds,
    output logic [3:0]  z_axis_tens,
    output logic [3:0]  z_axis_units,
    output logic [3:0]  left_button_hundreds,
    output logic [3:0]  left_button_tens,
    output logic [3:0]  left_button_units,
    output logic [3:0]  middle_button_hundreds,
    output logic [3:0]  middle_button_tens,
    output logic [3:0]  middle_button_units,
    output logic [3:0]  right_button_hundreds,
    output logic [3:0]  right_button_tens,
    output logic [3:0]  right_button_units,
    output logic        busy,
    output logic        done_tick
);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  iter_q, iter_d;

    logic [15:0] z_bin_q, z_bin_d;
    logic [15:0] l_bin_q, l_bin_d;
    logic [15:0] m_bin_q, m_bin_d;
    logic [15:0] r_bin_q, r_bin_d;

    logic [19:0] z_bcd_q, z_bcd_d;
    logic [11:0] l_bcd_q, l_bcd_d;
    logic [11:0] m_bcd_q, m_bcd_d;
    logic [11:0] r_bcd_q, r_bcd_d;

    logic [19:0] z_dig_q, z_dig_d;
    logic [11:0] l_dig_q, l_dig_d;
    logic [11:0] m_dig_q, m_dig_d;
    logic [11:0] r_dig_q, r_dig_d;

    logic [19:0] z_step;
    logic [11:0] l_step, m_step, r_step;

    function automatic logic [19:0] dab20(input logic [19:0] v);
        logic [19:0] r;
        r = v;
        for (int i = 0; i < 5; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    function automatic logic [11:0] dab12(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        for (int i = 0; i < 3; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Adjust, then shift with the binary MSB entering the BCD LSB.
    always_comb begin
        z_step = (dab20(z_bcd_q) << 1) | {19'd0, z_bin_q[15]};
        l_step = (dab12(l_bcd_q) << 1) | {11'd0, l_bin_q[15]};
        m_step = (dab12(m_bcd_q) << 1) | {11'd0, m_bin_q[15]};
        r_step = (dab12(r_bcd_q) << 1) | {11'd0, r_bin_q[15]};
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        z_bin_d = z_bin_q;
        l_bin_d = l_bin_q;
        m_bin_d = m_bin_q;
        r_bin_d = r_bin_q;
        z_bcd_d = z_bcd_q;
        l_bcd_d = l_bcd_q;
        m_bcd_d = m_bcd_q;
        r_bcd_d = r_bcd_q;
        z_dig_d = z_dig_q;
        l_dig_d = l_dig_q;
        m_dig_d = m_dig_q;
        r_dig_d = r_dig_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    z_bin_d = z_count;
                    l_bin_d = {8'd0, left_count};
                    m_bin_d = {8'd0, middle_count};
                    r_bin_d = {8'd0, right_count};
                    z_bcd_d = '0;
                    l_bcd_d = '0;
                    m_bcd_d = '0;
                    r_bcd_d = '0;
                    iter_d  = 4'd0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                z_bin_d = z_bin_q << 1;
                l_bin_d = l_bin_q << 1;
                m_bin_d = m_bin_q << 1;
                r_bin_d = r_bin_q << 1;
                z_bcd_d = z_step;
                l_bcd_d = l_step;
                m_bcd_d = m_step;
                r_bcd_d = r_step;
                iter_d  = iter_q + 4'd1;
                if (iter_q == 4'd15) begin
                    z_dig_d = z_step;
                    l_dig_d = l_step;
                    m_dig_d = m_step;
                    r_dig_d = r_step;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            iter_q  <= '0;
            z_bin_q <= '0;
            l_bin_q <= '0;
            m_bin_q <= '0;
            r_bin_q <= '0;
            z_bcd_q <= '0;
            l_bcd_q <= '0;
            m_bcd_q <= '0;
            r_bcd_q <= '0;
            z_dig_q <= '0;
            l_dig_q <= '0;
            m_dig_q <= '0;
            r_dig_q <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            z_bin_q <= z_bin_d;
            l_bin_q <= l_bin_d;
            m_bin_q <= m_bin_d;
            r_bin_q <= r_bin_d;
            z_bcd_q <= z_bcd_d;
            l_bcd_q <= l_bcd_d;
            m_bcd_q <= m_bcd_d;
            r_bcd_q <= r_bcd_d;
            z_dig_q <= z_dig_d;
            l_dig_q <= l_dig_d;
            m_dig_q <= m_dig_d;
            r_dig_q <= r_dig_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done_tick = (state_q == DONE);

    assign z_axis_ten_thousands   = z_dig_q[19:16];
    assign z_axis_thousands       = z_dig_q[15:12];
    assign z_axis_hundreds        = z_dig_q[11:8];
    assign z_axis_tens            = z_dig_q[7:4];
    assign z_axis_units           = z_dig_q[3:0];
    assign left_button_hundreds   = l_dig_q[11:8];
    assign left_button_tens       = l_dig_q[7:4];
    assign left_button_units      = l_dig_q[3:0];
    assign middle_button_hundreds = m_dig_q[11:8];
    assign middle_button_tens     = m_dig_q[7:4];
    assign middle_button_units    = m_dig_q[3:0];
    assign right_button_hundreds  = r_dig_q[11:8];
    assign right_button_tens      = r_dig_q[7:4];
    assign right_button_units     = r_dig_q[3:0];

endmodule

// File: tb/tb_ps2_counter_bcd.sv
// Directed bench for ps2_counter_bcd: vector table plus reset, back-to-back
// and ignored-start sequences.
module tb_ps2_counter_bcd;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] z_count;
    logic [7:0]  left_count, middle_count, right_count;
    logic [3:0]  z_tt, z_th, z_hu, z_te, z_un;
    logic [3:0]  l_hu, l_te, l_un, m_hu, m_te, m_un, r_hu, r_te, r_un;
    logic        busy, done_tick;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ps2_counter_bcd dut (
        .clk                    (clk),
        .reset                  (reset),
        .start                  (start),
        .z_count                (z_count),
        .left_count             (left_count),
        .middle_count           (middle_count),
        .right_count            (right_count),
        .z_axis_ten_thousands   (z_tt),
        .z_axis_thousands       (z_th),
        .z_axis_hundreds        (z_hu),
        .z_axis_tens            (z_te),
        .z_axis_units           (z_un),
        .left_button_hundreds   (l_hu),
        .left_button_tens       (l_te),
        .left_button_units      (l_un),
        .middle_button_hundreds (m_hu),
        .middle_button_tens     (m_te),
        .middle_button_units    (m_un),
        .right_button_hundreds  (r_hu),
        .right_button_tens      (r_te),
        .right_button_units     (r_un),
        .busy                   (busy),
        .done_tick              (done_tick)
    );

    typedef struct {
        logic [15:0] z;
        logic [7:0]  l;
        logic [7:0]  m;
        logic [7:0]  r;
        logic [55:0] exp;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [55:0] digits();
        return {z_tt, z_th, z_hu, z_te, z_un,
                l_hu, l_te, l_un, m_hu, m_te, m_un,
                r_hu, r_te, r_un};
    endfunction

    function automatic logic [11:0] bcd3(input int v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [55:0] model(input int z, input int l,
                                          input int m, input int r);
        return {4'((z / 10000) % 10), 4'((z / 1000) % 10),
                4'((z / 100) % 10), 4'((z / 10) % 10), 4'(z % 10),
                bcd3(l), bcd3(m), bcd3(r)};
    endfunction

    task automatic chk(input string name, input logic [55:0] act,
                       input logic [55:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle; ends in the IDLE cycle after DONE.
    task automatic conv(input vec_t v, input bit poke);
        logic [55:0] hold;
        z_count      = v.z;
        left_count   = v.l;
        middle_count = v.m;
        right_count  = v.r;
        start        = 1'b1;
        hold         = digits();
        tick();
        start        = 1'b0;
        z_count      = ~v.z;
        left_count   = ~v.l;
        middle_count = v.m + 8'd17;
        right_count  = v.r ^ 8'h5a;
        for (int c = 1; c <= 16; c++) begin
            chk("busy_convert", {55'd0, busy}, 56'd1);
            chk("no_done_convert", {55'd0, done_tick}, 56'd0);
            chk("digits_hold", digits(), hold);
            if (poke) start = (c == 5);
            tick();
        end
        chk("done_tick", {55'd0, done_tick}, 56'd1);
        chk("busy_done", {55'd0, busy}, 56'd1);
        chk("result", digits(), v.exp);
        if (poke) start = 1'b1;
        tick();
        start = 1'b0;
        chk("idle_after_done", {54'd0, busy, done_tick}, 56'd0);
    endtask

    initial begin
        logic [55:0] saved;
        int          ticks;

        vecs[0] = '{16'd12345, 8'd255, 8'd0,   8'd100,
                    56'h12345_255_000_100};
        vecs[1] = '{16'd65535, 8'd0,   8'd1,   8'd9,
                    56'h65535_000_001_009};
        vecs[2] = '{16'd9999,  8'd10,  8'd99,  8'd200,
                    56'h09999_010_099_200};
        vecs[3] = '{16'd10000, 8'd199, 8'd250, 8'd1,
                    56'h10000_199_250_001};
        vecs[4] = '{16'd0,     8'd0,   8'd0,   8'd0,
                    56'h00000_000_000_000};
        vecs[5] = '{16'd42,    8'd128, 8'd64,  8'd7,
                    56'h00042_128_064_007};

        reset = 1'b1;
        start = 1'b1;
        z_count = 16'd777;
        left_count = 8'd1;
        middle_count = 8'd2;
        right_count = 8'd3;
        tick();
        tick();
        chk("reset_digits", digits(), 56'd0);
        chk("reset_flags", {54'd0, busy, done_tick}, 56'd0);
        reset = 1'b0;
        start = 1'b0;

        foreach (vecs[i]) conv(vecs[i], 1'b0);

        // Start held high, inputs changing every cycle.
        saved = '0;
        for (int c = 0; c < 54; c++) begin
            chk("b2b_done", {55'd0, done_tick}, {55'd0, (c % 18) == 17});
            if ((c % 18) == 17) chk("b2b_result", digits(), saved);
            z_count      = 16'(c * 1237 + 100);
            left_count   = 8'(c * 3);
            middle_count = 8'(c);
            right_count  = 8'(255 - c);
            if ((c % 18) == 0)
                saved = model(c * 1237 + 100, c * 3, c, 255 - c);
            start = 1'b1;
            if (c == 53) start = 1'b0;
            tick();
        end
        chk("b2b_idle", {54'd0, busy, done_tick}, 56'd0);

        // Reset in CONVERT cycle 8 after a 00042 result.
        conv('{16'd42, 8'd0, 8'd0, 8'd0, 56'h00042_000_000_000}, 1'b0);
        z_count = 16'd54321;
        left_count = 8'd200;
        middle_count = 8'd5;
        right_count = 8'd250;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        chk("pre_abort_digits", digits(), 56'h00042_000_000_000);
        reset = 1'b1;
        tick();
        chk("abort_digits", digits(), 56'd0);
        chk("abort_flags", {54'd0, busy, done_tick}, 56'd0);
        reset = 1'b0;
        conv('{16'd31415, 8'd92, 8'd65, 8'd35,
               56'h31415_092_065_035}, 1'b0);

        // Start pulses in CONVERT and DONE are dropped.
        conv('{16'd2024, 8'd12, 8'd34, 8'd56,
               56'h02024_012_034_056}, 1'b1);
        ticks = 0;
        for (int c = 0; c < 20; c++) begin
            if (done_tick || busy) ticks++;
            tick();
        end
        chk("no_extra_conversion", 56'(ticks), 56'd0);
        chk("digits_kept", digits(), 56'h02024_012_034_056);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
